// File: rtl/spi_sram_controller_pkg.sv
// Shared types, opcodes and frame construction for the SPI SRAM controller.
package spi_sram_controller_pkg;

   localparam int unsigned DIV_W   = 8;
   localparam int unsigned BYTE_W  = 8;
   localparam int unsigned WORD_W  = 16;
   localparam int unsigned FRAME_W = 40;
   localparam int unsigned IDX_W   = 3;

   localparam logic [BYTE_W-1:0] CMD_READ  = 8'h03;
   localparam logic [BYTE_W-1:0] CMD_WRITE = 8'h02;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_CS_SETUP = 3'd1,
      ST_SHIFT    = 3'd2,
      ST_CS_HOLD  = 3'd3,
      ST_DONE     = 3'd4
   } state_e;

   // Latched request: outgoing bytes left-aligned in frame, consumed MSB byte first.
   typedef struct packed {
      logic               we;
      logic [IDX_W-1:0]   n_bytes;
      logic [FRAME_W-1:0] frame;
   } req_t;

   function automatic req_t build_req(input logic              we,
                                      input logic [WORD_W-1:0] addr,
                                      input logic [WORD_W-1:0] data,
                                      input logic [1:0]        mask);
      req_t              r;
      logic [WORD_W-1:0] addr_p1;
      addr_p1 = addr + WORD_W'(1);
      r.we    = we;
      if (!we) begin
         r.n_bytes = IDX_W'(5);
         r.frame   = {CMD_READ, addr, 16'h0000};
      end else if (mask == 2'b11) begin
         r.n_bytes = IDX_W'(5);
         r.frame   = {CMD_WRITE, addr, data[7:0], data[15:8]};
      end else if (mask == 2'b01) begin
         r.n_bytes = IDX_W'(4);
         r.frame   = {CMD_WRITE, addr, data[7:0], 8'h00};
      end else begin
         r.n_bytes = IDX_W'(4);
         r.frame   = {CMD_WRITE, addr_p1, data[15:8], 8'h00};
      end
      return r;
   endfunction

endpackage

// File: rtl/spi_sram_controller_byte_shifter.sv
// Shifts one byte out on MOSI (MSB first) and one byte in from MISO per load, mode 0.
module spi_byte_shifter
   import spi_sram_controller_pkg::*;
#(
   parameter int unsigned CLOCK_DIVIDE = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              load,
   input  logic [BYTE_W-1:0] tx_byte,
   input  logic              miso,
   output logic              sclk,
   output logic              mosi,
   output logic [BYTE_W-1:0] rx_byte,
   output logic              last_cycle_c
);

   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLOCK_DIVIDE - 1);

   logic              active_q, active_d;
   logic              phase_q, phase_d;
   logic [DIV_W-1:0]  div_q, div_d;
   logic [2:0]        bit_q, bit_d;
   logic [BYTE_W-1:0] tx_q, tx_d;
   logic [BYTE_W-1:0] rx_q, rx_d;
   logic              sclk_q, sclk_d;
   logic              mosi_q, mosi_d;
   logic              div_end;

   assign div_end      = (div_q == DIV_LAST);
   assign last_cycle_c = active_q & phase_q & div_end & (bit_q == 3'd7);
   assign sclk         = sclk_q;
   assign mosi         = mosi_q;
   assign rx_byte      = rx_q;

   // A load always restarts a byte; the controller issues it on the final cycle of the previous one.
   always_comb begin
      active_d = active_q;
      phase_d  = phase_q;
      div_d    = div_q;
      bit_d    = bit_q;
      tx_d     = tx_q;
      rx_d     = rx_q;
      sclk_d   = sclk_q;
      mosi_d   = mosi_q;
      if (load) begin
         active_d = 1'b1;
         phase_d  = 1'b0;
         div_d    = '0;
         bit_d    = 3'd0;
         tx_d     = {tx_byte[6:0], 1'b0};
         mosi_d   = tx_byte[7];
         sclk_d   = 1'b0;
      end else if (active_q) begin
         if (!div_end) begin
            div_d = div_q + DIV_W'(1);
         end else begin
            div_d = '0;
            if (!phase_q) begin
               phase_d = 1'b1;
               sclk_d  = 1'b1;
               rx_d    = {rx_q[6:0], miso};
            end else begin
               phase_d = 1'b0;
               sclk_d  = 1'b0;
               if (bit_q == 3'd7) begin
                  active_d = 1'b0;
                  mosi_d   = 1'b0;
               end else begin
                  bit_d  = bit_q + 3'd1;
                  mosi_d = tx_q[7];
                  tx_d   = {tx_q[6:0], 1'b0};
               end
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         active_q <= 1'b0;
         phase_q  <= 1'b0;
         div_q    <= '0;
         bit_q    <= 3'd0;
         tx_q     <= '0;
         rx_q     <= '0;
         sclk_q   <= 1'b0;
         mosi_q   <= 1'b0;
      end else begin
         active_q <= active_d;
         phase_q  <= phase_d;
         div_q    <= div_d;
         bit_q    <= bit_d;
         tx_q     <= tx_d;
         rx_q     <= rx_d;
         sclk_q   <= sclk_d;
         mosi_q   <= mosi_d;
      end
   end

endmodule

// File: rtl/spi_sram_controller.sv
// Memory-bus to SPI SRAM bridge: sequences command/address/data bytes through spi_byte_shifter.
module spi_sram_controller
   import spi_sram_controller_pkg::*;
#(
   parameter int unsigned CLOCK_DIVIDE = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              write_enable,
   input  logic [WORD_W-1:0] address,
   input  logic [WORD_W-1:0] data_in,
   input  logic [1:0]        write_mask,
   output logic [WORD_W-1:0] data_out,
   output logic              busy,
   output logic              done,
   output logic              spi_cs_n,
   output logic              spi_clk,
   output logic              spi_mosi,
   input  logic              spi_miso
);

   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLOCK_DIVIDE - 1);

   state_e            state_q, state_d;
   logic [DIV_W-1:0]  cnt_q, cnt_d;
   req_t              req_q, req_d;
   logic [IDX_W-1:0]  byte_idx_q, byte_idx_d;
   logic [WORD_W-1:0] rd_q, rd_d;
   logic [WORD_W-1:0] data_out_q, data_out_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic              cs_n_q, cs_n_d;

   logic              load_c;
   logic [BYTE_W-1:0] tx_byte_c;
   logic              last_cycle_c;
   logic [BYTE_W-1:0] rx_byte;
   logic              cnt_end;

   assign cnt_end  = (cnt_q == DIV_LAST);
   assign data_out = data_out_q;
   assign busy     = busy_q;
   assign done     = done_q;
   assign spi_cs_n = cs_n_q;

   spi_byte_shifter #(
      .CLOCK_DIVIDE (CLOCK_DIVIDE)
   ) u_shifter (
      .clk          (clk),
      .reset        (reset),
      .load         (load_c),
      .tx_byte      (tx_byte_c),
      .miso         (spi_miso),
      .sclk         (spi_clk),
      .mosi         (spi_mosi),
      .rx_byte      (rx_byte),
      .last_cycle_c (last_cycle_c)
   );

   // Next-state, byte sequencing and next values of the registered outputs.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      req_d      = req_q;
      byte_idx_d = byte_idx_q;
      rd_d       = rd_q;
      data_out_d = data_out_q;
      load_c     = 1'b0;
      tx_byte_c  = req_q.frame[FRAME_W-1 -: BYTE_W];

      unique case (state_q)
         ST_IDLE: begin
            if (start) begin
               if (write_enable && (write_mask == 2'b00)) begin
                  state_d = ST_DONE;
               end else begin
                  req_d   = build_req(write_enable, address, data_in, write_mask);
                  cnt_d   = '0;
                  state_d = ST_CS_SETUP;
               end
            end
         end
         ST_CS_SETUP: begin
            if (cnt_end) begin
               load_c      = 1'b1;
               req_d.frame = {req_q.frame[FRAME_W-BYTE_W-1:0], 8'h00};
               byte_idx_d  = IDX_W'(1);
               cnt_d       = '0;
               state_d     = ST_SHIFT;
            end else begin
               cnt_d = cnt_q + DIV_W'(1);
            end
         end
         ST_SHIFT: begin
            if (last_cycle_c) begin
               // Read data bytes arrive low byte first as frame bytes 4 and 5.
               if (byte_idx_q == IDX_W'(4)) rd_d[7:0]  = rx_byte;
               if (byte_idx_q == IDX_W'(5)) rd_d[15:8] = rx_byte;
               if (byte_idx_q == req_q.n_bytes) begin
                  cnt_d   = '0;
                  state_d = ST_CS_HOLD;
               end else begin
                  load_c      = 1'b1;
                  req_d.frame = {req_q.frame[FRAME_W-BYTE_W-1:0], 8'h00};
                  byte_idx_d  = byte_idx_q + IDX_W'(1);
               end
            end
         end
         ST_CS_HOLD: begin
            if (cnt_end) begin
               state_d = ST_DONE;
               if (!req_q.we) data_out_d = rd_q;
            end else begin
               cnt_d = cnt_q + DIV_W'(1);
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      busy_d = (state_d != ST_IDLE);
      done_d = (state_d == ST_DONE);
      cs_n_d = !((state_d == ST_CS_SETUP) || (state_d == ST_SHIFT) || (state_d == ST_CS_HOLD));
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q    <= ST_IDLE;
         cnt_q      <= '0;
         req_q      <= '0;
         byte_idx_q <= '0;
         rd_q       <= '0;
         data_out_q <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         cs_n_q     <= 1'b1;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         req_q      <= req_d;
         byte_idx_q <= byte_idx_d;
         rd_q       <= rd_d;
         data_out_q <= data_out_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         cs_n_q     <= cs_n_d;
      end
   end

endmodule

// File: tb/tb_spi_sram_controller.sv
// Scoreboard bench for spi_sram_controller with an SPI SRAM slave model and a byte-level reference memory.
module tb_spi_sram_controller;

   localparam int unsigned DIV = 4;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        start = 1'b0;
   logic        write_enable = 1'b0;
   logic [15:0] address = '0;
   logic [15:0] data_in = '0;
   logic [1:0]  write_mask = '0;
   logic [15:0] data_out;
   logic        busy;
   logic        done;
   logic        spi_cs_n;
   logic        spi_clk;
   logic        spi_mosi;
   logic        spi_miso = 1'b0;

   int n_cmp = 0;
   int n_err = 0;
   int cyc   = 0;

   spi_sram_controller #(.CLOCK_DIVIDE(DIV)) dut (
      .clk          (clk),
      .reset        (reset),
      .start        (start),
      .write_enable (write_enable),
      .address      (address),
      .data_in      (data_in),
      .write_mask   (write_mask),
      .data_out     (data_out),
      .busy         (busy),
      .done         (done),
      .spi_cs_n     (spi_cs_n),
      .spi_clk      (spi_clk),
      .spi_mosi     (spi_mosi),
      .spi_miso     (spi_miso)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct packed {
      logic [3:0]  n;
      logic [39:0] b;
   } frame_t;

   typedef struct packed {
      logic [3:0]  n;
      logic [39:0] frame;
      logic [15:0] data;
      int          lat;
      int          start_cyc;
   } exp_t;

   exp_t   sb[$];
   frame_t frames[$];

   logic [7:0] slv_mem [logic [15:0]];
   logic [7:0] ref_mem [logic [15:0]];
   logic [15:0] last_rd = 16'h0000;

   function automatic logic [7:0] init_byte(input logic [15:0] a);
      return a[7:0] ^ a[15:8] ^ 8'h5A;
   endfunction

   function automatic logic [7:0] slv_rd(input logic [15:0] a);
      return slv_mem.exists(a) ? slv_mem[a] : init_byte(a);
   endfunction

   function automatic logic [7:0] ref_rd(input logic [15:0] a);
      return ref_mem.exists(a) ? ref_mem[a] : init_byte(a);
   endfunction

   task automatic check(input string name, input logic [47:0] act, input logic [47:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // SPI SRAM slave: samples MOSI on spi_clk rise, drives MISO after spi_clk fall.
   logic       cs_prev = 1'b1;
   logic       sclk_prev = 1'b0;
   int         s_bits, s_obits, fr_n;
   logic [7:0] s_sh, s_cmd, s_out;
   logic [15:0] s_addr, s_rptr;
   logic [39:0] fr_b;
   bit         s_rd;

   always @(spi_clk or spi_cs_n) begin
      if (spi_cs_n !== cs_prev) begin
         if (spi_cs_n === 1'b0) begin
            s_bits = 0; s_obits = 0; s_rd = 0; fr_n = 0; fr_b = '0;
         end else if (spi_cs_n === 1'b1) begin
            spi_miso = 1'b0;
            if (reset === 1'b1) frames.push_back('{n: 4'(fr_n), b: fr_b << (8 * (5 - fr_n))});
            s_rd = 0;
         end
      end else if (spi_clk !== sclk_prev && spi_cs_n === 1'b0) begin
         if (spi_clk === 1'b1) begin
            s_sh = {s_sh[6:0], spi_mosi};
            s_bits++;
            if (s_bits % 8 == 0) begin
               fr_b = {fr_b[31:0], s_sh};
               fr_n++;
               case (s_bits)
                  8:  s_cmd = s_sh;
                  16: s_addr[15:8] = s_sh;
                  24: begin
                     s_addr[7:0] = s_sh;
                     s_rptr = s_addr;
                     s_rd = (s_cmd == 8'h03);
                  end
                  default: if (s_cmd == 8'h02) begin
                     slv_mem[s_addr] = s_sh;
                     s_addr = s_addr + 16'd1;
                  end
               endcase
            end
         end else if (s_rd) begin
            if (s_obits % 8 == 0) begin
               s_out = slv_rd(s_rptr);
               s_rptr = s_rptr + 16'd1;
            end
            spi_miso = s_out[7];
            s_out = {s_out[6:0], 1'b0};
            s_obits++;
         end
      end
      cs_prev = spi_cs_n;
      sclk_prev = spi_clk;
   end

   // Monitor: every done pulse is matched against the oldest scoreboard entry.
   always @(negedge clk) begin
      if (reset === 1'b1 && done === 1'b1) begin
         if (sb.size() == 0) begin
            check("unexpected_done", 48'(1), 48'(0));
         end else begin
            exp_t   e;
            frame_t f;
            e = sb.pop_front();
            check("latency", 48'(cyc - e.start_cyc), 48'(e.lat));
            check("data_out", 48'(data_out), 48'(e.data));
            check("busy_at_done", 48'(busy), 48'(1));
            if (e.n == 4'd0) begin
               check("spi_frames_for_mask00", 48'(frames.size()), 48'(0));
            end else if (frames.size() == 0) begin
               check("spi_frame_present", 48'(0), 48'(1));
            end else begin
               f = frames.pop_front();
               check("mosi_byte_count", 48'(f.n), 48'(e.n));
               check("mosi_bytes", 48'(f.b), 48'(e.frame));
            end
         end
      end
   end

   task automatic finish_sim();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   endtask

   // Reference: expected frame, latency and data_out from the bus request alone.
   task automatic push_expect(input logic we, input logic [15:0] a, input logic [15:0] d,
                              input logic [1:0] m, output int lat);
      exp_t       e;
      logic [7:0] q[$];
      logic [15:0] a1;
      a1 = a + 16'd1;
      if (!we)          q = '{8'h03, a[15:8], a[7:0], 8'h00, 8'h00};
      else if (m == 3)  q = '{8'h02, a[15:8], a[7:0], d[7:0], d[15:8]};
      else if (m == 1)  q = '{8'h02, a[15:8], a[7:0], d[7:0]};
      else if (m == 2)  q = '{8'h02, a1[15:8], a1[7:0], d[15:8]};
      else              q = '{};
      e.frame = '0;
      foreach (q[i]) e.frame[39 - 8*i -: 8] = q[i];
      e.n = 4'(q.size());
      e.lat = (q.size() == 0) ? 1 : 2 * DIV * 8 * q.size() + 2 * DIV + 1;
      if (we) begin
         if (m[0]) ref_mem[a] = d[7:0];
         if (m[1]) ref_mem[a1] = d[15:8];
      end else begin
         last_rd = {ref_rd(a1), ref_rd(a)};
      end
      e.data = last_rd;
      e.start_cyc = cyc;
      lat = e.lat;
      sb.push_back(e);
   endtask

   task automatic run_txn(input logic we, input logic [15:0] a, input logic [15:0] d,
                          input logic [1:0] m, input bit glitch);
      int lat, g, k;
      @(negedge clk);
      push_expect(we, a, d, m, lat);
      write_enable = we; address = a; data_in = d; write_mask = m; start = 1'b1;
      g = (glitch && lat > 8) ? int'($urandom_range(2, lat - 3)) : -1;
      k = 0;
      forever begin
         @(negedge clk);
         start = 1'b0;
         if (done === 1'b1) break;
         if (k == g) begin
            start = 1'b1;
            write_enable = 1'($urandom);
            address = 16'($urandom);
            data_in = 16'($urandom);
            write_mask = 2'($urandom);
         end
         k++;
         if (k > 3000) begin
            n_cmp++; n_err++;
            $display("FAIL done_timeout: no done after %0d cycles", k);
            finish_sim();
         end
      end
   endtask

   initial begin
      repeat (3) @(negedge clk);
      check("rst_cs_n", 48'(spi_cs_n), 48'(1));
      check("rst_spi_clk", 48'(spi_clk), 48'(0));
      check("rst_mosi", 48'(spi_mosi), 48'(0));
      check("rst_busy", 48'(busy), 48'(0));
      check("rst_done", 48'(done), 48'(0));
      check("rst_data_out", 48'(data_out), 48'(0));
      reset = 1'b1;

      slv_mem[16'h1234] = 8'hCD; slv_mem[16'h1235] = 8'hAB;
      ref_mem[16'h1234] = 8'hCD; ref_mem[16'h1235] = 8'hAB;

      run_txn(1'b0, 16'h1234, 16'h0000, 2'b00, 1'b1);
      run_txn(1'b1, 16'h0100, 16'hBEEF, 2'b11, 1'b1);
      run_txn(1'b1, 16'hFFFE, 16'h5A00, 2'b10, 1'b0);
      run_txn(1'b1, 16'h0010, 16'h1111, 2'b00, 1'b0);
      run_txn(1'b0, 16'h0100, 16'h0000, 2'b00, 1'b0);
      run_txn(1'b0, 16'hFFFE, 16'h0000, 2'b11, 1'b0);

      // Abort a read around bit 12 of the frame.
      @(negedge clk);
      write_enable = 1'b0; address = 16'h0040; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (DIV + 12 * 2 * DIV - 1) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      check("abort_cs_n", 48'(spi_cs_n), 48'(1));
      check("abort_spi_clk", 48'(spi_clk), 48'(0));
      check("abort_busy", 48'(busy), 48'(0));
      check("abort_done", 48'(done), 48'(0));
      check("abort_data_out", 48'(data_out), 48'(0));
      repeat (3) @(negedge clk);
      check("abort_no_done", 48'(done), 48'(0));
      last_rd = 16'h0000;
      reset = 1'b1;
      run_txn(1'b0, 16'h1234, 16'h0000, 2'b00, 1'b0);

      for (int i = 0; i < 30; i++) begin
         logic [15:0] a;
         a = ($urandom_range(0, 9) == 0) ? 16'hFFFE : 16'(16'($urandom_range(0, 7)) << 1);
         run_txn(1'($urandom_range(0, 9) >= 4), a, 16'($urandom), 2'($urandom),
                 1'($urandom_range(0, 2) == 0));
      end

      repeat (4) @(negedge clk);
      check("scoreboard_drained", 48'(sb.size()), 48'(0));
      check("final_idle_cs_n", 48'(spi_cs_n), 48'(1));
      finish_sim();
   end

endmodule

// File: doc/spi_sram_controller.md
SPI_SRAM_CONTROLLER -- requirements
Module: spi_sram_controller

Interface
REQ-001 CLOCK_DIVIDE, 4, clk cycles per SPI clock half-period; legal range 1..255.
REQ-002 clk  input  1  single system clock; all logic on rising edge.
REQ-003 reset  input  1  synchronous, active-low reset.
REQ-004 start  input  1  one-cycle request strobe from memory_bus; sampled only when idle.
REQ-005 write_enable  input  1  1 = write transaction, 0 = read; sampled with start.
REQ-006 address  input  16  byte address; bit 0 SHALL be 0 (word aligned), sampled with start.
REQ-007 data_in  input  16  write data; low byte at address, high byte at address+1; sampled with start.
REQ-008 write_mask  input  2  bit0 = write low byte, bit1 = write high byte; sampled with start.
REQ-009 data_out  output  16  last read word; held until next read completes.
REQ-010 busy  output  1  high from cycle after accepted start until done cycle inclusive.
REQ-011 done  output  1  one-cycle pulse at transaction completion; memory_bus stalls CPU until it.
REQ-012 spi_cs_n  output  1  SRAM chip select, active low.
REQ-013 spi_clk  output  1  SPI clock, mode 0, idle low.
REQ-014 spi_mosi  output  1  serial data to SRAM, MSB first.
REQ-015 spi_miso  input  1  serial data from SRAM.

Function
REQ-016 States SHALL be IDLE, CS_SETUP, SHIFT, CS_HOLD, DONE.
REQ-017 IDLE: start=1 with write_enable=0, or write_mask!=00, latches request, goes to CS_SETUP; write with mask 00 goes directly to DONE (no SPI activity).
REQ-018 start while busy SHALL be ignored with no effect on the transaction in progress.
REQ-019 CS_SETUP: spi_cs_n low, spi_clk low, lasts CLOCK_DIVIDE cycles, then SHIFT.
REQ-020 Byte sequence, read: 0x03, addr[15:8], addr[7:0], then 2 received bytes (low byte first, 0x00 driven on MOSI).
REQ-021 Write mask 11: 0x02, addr hi, addr lo, data_in[7:0], data_in[15:8].
REQ-022 Write mask 01: 0x02, address, data_in[7:0]; mask 10: 0x02, address+1, data_in[15:8].
REQ-023 Each bit: spi_clk low CLOCK_DIVIDE cycles then high CLOCK_DIVIDE cycles; MOSI changes only while spi_clk low; MISO sampled on the cycle spi_clk rises.
REQ-024 After last bit, CS_HOLD: spi_clk low, spi_cs_n low for CLOCK_DIVIDE cycles, then spi_cs_n high entering DONE.
REQ-025 DONE: done=1 for exactly one cycle, read result written to data_out same cycle, return to IDLE.
REQ-026 Latency: done SHALL be high N cycles after the start cycle, N = 2*CLOCK_DIVIDE*bits + 2*CLOCK_DIVIDE + 1; bits = 40 read / write-11, 32 write-01/10; write-00 N = 1.
REQ-027 Writes SHALL NOT modify data_out.
REQ-028 start accepted the cycle after done SHALL begin a new transaction (back-to-back allowed).
REQ-029 Address+1 for mask 10 SHALL wrap 0xFFFF->0x0000 (16-bit arithmetic).

Reset
REQ-030 reset low SHALL, on the next edge, force: state IDLE, spi_cs_n 1, spi_clk 0, spi_mosi 0, busy 0, done 0, data_out 0x0000.
REQ-031 Reset mid-transaction SHALL abort without a done pulse and leave data_out 0x0000.

Structure
REQ-032 Shared package SHALL hold state encoding, opcodes CMD_READ=0x03 and CMD_WRITE=0x02.
REQ-033 Single sub-module spi_byte_shifter SHALL shift one byte out/in per load, with CLOCK_DIVIDE timing; controller sequences bytes.

Verification
REQ-034 Read 0x1234, SRAM model returns 0xCD,0xAB -> MOSI 03 12 34 00 00, data_out 0xABCD, done at cycle 329 (DIV=4).
REQ-035 Write 0x0100, data 0xBEEF, mask 11 -> MOSI 02 01 00 EF BE, data_out unchanged, done at cycle 329.
REQ-036 Write 0xFFFE, data 0x5A00, mask 10 -> MOSI 02 FF FF 5A, done at cycle 265.
REQ-037 Write mask 00 -> spi_cs_n stays 1, done at cycle 1; start during busy read -> ignored, single done.
REQ-038 Assert reset at bit 12 of a read -> next edge spi_cs_n 1, spi_clk 0, busy 0, no done, data_out 0x0000; following read completes normally.
